// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster scan controller with two-stage blanking/sync output pipeline
//
// Purpose:
//   Walks hcount/vcount across the full raster one position per pix_en strobe.
//   Active/sync decode of the current position is registered (stage 1), then
//   combined with the generator colour to drive blanked RGB and active-low syncs
//   (stage 2). Dropping run lets the current frame finish before going idle.
//
// Ports:
//   clock, reset_n          - system clock, asynchronous active-low reset
//   pix_en                  - one-clock pixel-step strobe; nothing moves without it
//   run                     - level request to scan
//   hcount, vcount          - raster position to the pixel generator
//   gen_enable              - pixel generator enable (always 1)
//   gen_red/green/blue      - generator colour, registered one clock after counters
//   vga_red/green/blue      - blanked colour to the DAC
//   hsync_n, vsync_n        - active-low syncs
//   frame_start             - one-clock pulse after the step that consumes (0,0)
//   busy                    - scanner is not idle
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic       run,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       gen_enable,
    input  logic [2:0] gen_red,
    input  logic [2:0] gen_green,
    input  logic [1:0] gen_blue,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start,
    output logic       busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0] r_state;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_s1_active;
    logic       r_s1_hs;
    logic       r_s1_vs;
    logic [2:0] r_vga_red;
    logic [2:0] r_vga_green;
    logic [1:0] r_vga_blue;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_frame_start;

    logic [1:0] w_state_next;
    logic       w_advance;
    logic       w_h_wrap;
    logic       w_at_end;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_scanning;
    logic       w_active;
    logic       w_hs;
    logic       w_vs;
    logic       w_at_origin;

    assign w_scanning  = (r_state != ST_IDLE);
    assign w_h_wrap    = (r_hcount == H_LAST);
    assign w_at_end    = w_h_wrap && (r_vcount == V_LAST);
    assign w_at_origin = (r_hcount == 10'd0) && (r_vcount == 10'd0);

    assign w_h_next = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
    assign w_v_next = !w_h_wrap ? r_vcount
                    : ((r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1);

    // Position decode feeding stage 1; all of it is suppressed while idle.
    assign w_active = w_scanning && (r_hcount < H_ACT_END) && (r_vcount < V_ACT_END);
    assign w_hs     = w_scanning && (r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST);
    assign w_vs     = w_scanning && (r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST);

    // The idle->run step only arms the scanner; every step taken from RUN or
    // DRAIN consumes one raster position. The final drain step lands on (0,0)
    // through the normal wrap, so leaving DRAIN needs no separate clear.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = run ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                w_state_next = run ? ST_RUN : ST_DRAIN;
                w_advance    = 1'b1;
            end
            ST_DRAIN: begin
                w_advance = 1'b1;
                if (run) begin
                    w_state_next = ST_RUN;
                end else if (w_at_end) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_hcount      <= 10'd0;
            r_vcount      <= 10'd0;
            r_s1_active   <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
            r_vga_red     <= 3'd0;
            r_vga_green   <= 3'd0;
            r_vga_blue    <= 2'd0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (pix_en) begin
                r_state <= w_state_next;
                if (w_advance) begin
                    r_hcount <= w_h_next;
                    r_vcount <= w_v_next;
                end
                r_s1_active <= w_active;
                r_s1_hs     <= w_hs;
                r_s1_vs     <= w_vs;
                // gen_* now carries the colour for the position stage 1 holds.
                r_vga_red   <= r_s1_active ? gen_red   : 3'd0;
                r_vga_green <= r_s1_active ? gen_green : 3'd0;
                r_vga_blue  <= r_s1_active ? gen_blue  : 2'd0;
                r_hsync_n   <= ~r_s1_hs;
                r_vsync_n   <= ~r_s1_vs;
                r_frame_start <= w_scanning && w_at_origin;
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign gen_enable  = 1'b1;
    assign vga_red     = r_vga_red;
    assign vga_green   = r_vga_green;
    assign vga_blue    = r_vga_blue;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign frame_start = r_frame_start;
    assign busy        = w_scanning;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench for vga_scan_ctrl on a reduced raster
module tb_vga_scan_ctrl;

    localparam int HA = 6, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 13
    localparam int VT = VA + VF + VS + VB;   // 8

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pix_en;
    logic       run;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       gen_enable;
    logic [2:0] gen_red;
    logic [2:0] gen_green;
    logic [1:0] gen_blue;
    logic [2:0] vga_red;
    logic [2:0] vga_green;
    logic [1:0] vga_blue;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;
    logic       busy;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pix_en(pix_en), .run(run),
        .hcount(hcount), .vcount(vcount), .gen_enable(gen_enable),
        .gen_red(gen_red), .gen_green(gen_green), .gen_blue(gen_blue),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start(frame_start), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural raster model: position, scanning/finishing flags, and the
    // decode of the previously consumed position waiting to reach the outputs.
    bit         m_on, m_drain;
    int         m_h, m_v;
    bit         p_vis, p_hs, p_vs;
    logic [7:0] e_rgb;
    bit         e_hs_n, e_vs_n, e_fs;
    bit         gen_const;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("hcount", {22'd0, hcount}, m_h);
        chk("vcount", {22'd0, vcount}, m_v);
        chk("busy", {31'd0, busy}, {31'd0, m_on});
        chk("gen_enable", {31'd0, gen_enable}, 1);
        chk("vga_rgb", {24'd0, vga_red, vga_green, vga_blue}, {24'd0, e_rgb});
        chk("hsync_n", {31'd0, hsync_n}, {31'd0, e_hs_n});
        chk("vsync_n", {31'd0, vsync_n}, {31'd0, e_vs_n});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    endtask

    task automatic model_reset();
        m_on = 0; m_drain = 0; m_h = 0; m_v = 0;
        p_vis = 0; p_hs = 0; p_vs = 0;
        e_rgb = 8'd0; e_hs_n = 1; e_vs_n = 1; e_fs = 0;
    endtask

    task automatic model_step(input bit r, input logic [7:0] g_at_edge);
        int  ph  = m_h;
        int  pv  = m_v;
        bit  pon = m_on;
        e_rgb  = p_vis ? g_at_edge : 8'd0;
        e_hs_n = !p_hs;
        e_vs_n = !p_vs;
        p_vis  = pon && ph < HA && pv < VA;
        p_hs   = pon && ph >= HA + HF && ph < HA + HF + HS;
        p_vs   = pon && pv >= VA + VF && pv < VA + VF + VS;
        e_fs   = pon && ph == 0 && pv == 0;
        if (!pon) begin
            m_on = r;
        end else if (m_drain && !r && ph == HT - 1 && pv == VT - 1) begin
            m_on = 0; m_drain = 0; m_h = 0; m_v = 0;
        end else begin
            m_drain = !r;
            m_h = (ph + 1) % HT;
            if (m_h == 0) m_v = (pv + 1) % VT;
        end
    endtask

    function automatic logic [7:0] colour(input int h, input int v);
        logic [2:0] r3 = 3'(h + 1);
        logic [2:0] g3 = 3'(v + 2);
        logic [1:0] b2 = 2'(h + v);
        return gen_const ? 8'hFF : {r3, g3, b2};
    endfunction

    // One clock: step the model on pix_en edges, emulate the generator that
    // registers the colour of the counters it saw at this edge, then compare.
    task automatic tick(input bit pe);
        logic [7:0] g_before = {gen_red, gen_green, gen_blue};
        int ph = m_h;
        int pv = m_v;
        pix_en = pe;
        @(posedge clock);
        #1;
        if (pe) model_step(run, g_before);
        else    e_fs = 0;
        {gen_red, gen_green, gen_blue} = colour(ph, pv);
        compare_all();
    endtask

    int nz, hl, vl, fs, steps;

    task automatic count_clear();
        nz = 0; hl = 0; vl = 0; fs = 0;
    endtask

    task automatic count_step();
        if ({vga_red, vga_green, vga_blue} != 8'd0) nz++;
        if (!hsync_n) hl++;
        if (!vsync_n) vl++;
        if (frame_start) fs++;
    endtask

    initial begin
        reset_n = 1'b0; pix_en = 1'b0; run = 1'b0;
        gen_red = 3'd0; gen_green = 3'd0; gen_blue = 2'd0;
        gen_const = 1'b1;
        model_reset();
        #12;
        chk("rst_hcount", {22'd0, hcount}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_hsync_n", {31'd0, hsync_n}, 1);
        chk("rst_vsync_n", {31'd0, vsync_n}, 1);
        compare_all();
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick(0); tick(0);

        // Start of scan, pix_en every clock
        run = 1'b1;
        tick(1);
        chk("lit_busy_after_1", {31'd0, busy}, 1);
        chk("lit_h_after_1", {22'd0, hcount}, 0);
        tick(1);
        chk("lit_fs_after_2", {31'd0, frame_start}, 1);
        chk("lit_h_after_2", {22'd0, hcount}, 1);
        repeat (11) tick(1);
        chk("lit_h_last", {22'd0, hcount}, HT - 1);
        chk("lit_v_line0", {22'd0, vcount}, 0);
        tick(1);
        chk("lit_h_wrap", {22'd0, hcount}, 0);
        chk("lit_v_line1", {22'd0, vcount}, 1);

        repeat (2 * HT * VT) tick(1);
        count_clear();
        for (int i = 0; i < HT * VT; i++) begin
            tick(1);
            count_step();
        end
        chk("lit_visible_steps", nz, HA * VA);
        chk("lit_hsync_steps", hl, HS * VT);
        chk("lit_vsync_steps", vl, VS * HT);
        chk("lit_frame_pulses", fs, 1);

        // Varying colour pattern, checked through the model only
        gen_const = 1'b0;
        repeat (150) tick(1);

        // pix_en every 4th clock
        gen_const = 1'b1;
        repeat (8) begin tick(1); repeat (3) tick(0); end
        count_clear();
        for (int i = 0; i < HT * VT; i++) begin
            tick(1);
            count_step();
            repeat (3) tick(0);
        end
        chk("lit_slow_visible", nz, HA * VA);
        chk("lit_slow_hsync", hl, HS * VT);
        chk("lit_slow_vsync", vl, VS * HT);
        chk("lit_slow_frames", fs, 1);

        // Drop run mid-frame at (5,2), toggle it once during the drain
        gen_const = 1'b0;
        for (int i = 0; i < 300 && !(m_h == 5 && m_v == 2); i++) tick(1);
        chk("reach_5_2", (m_h == 5 && m_v == 2) ? 1 : 0, 1);
        run = 1'b0;
        steps = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            run = (steps == 10);
            tick(1);
            steps++;
        end
        run = 1'b0;
        chk("lit_drain_steps", steps, HT * VT - (2 * HT + 5));
        count_clear();
        repeat (20) begin tick(1); count_step(); end
        chk("lit_idle_frames", fs, 0);
        chk("lit_idle_hcount", {22'd0, hcount}, 0);
        chk("lit_idle_busy", {31'd0, busy}, 0);

        // Asynchronous reset mid-frame
        run = 1'b1;
        for (int i = 0; i < 300 && !(m_h == 7 && m_v == 3); i++) tick(1);
        chk("reach_7_3", (m_h == 7 && m_v == 3) ? 1 : 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_hcount", {22'd0, hcount}, 0);
        chk("arst_vcount", {22'd0, vcount}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_rgb", {24'd0, vga_red, vga_green, vga_blue}, 0);
        chk("arst_hsync_n", {31'd0, hsync_n}, 1);
        chk("arst_vsync_n", {31'd0, vsync_n}, 1);
        chk("arst_frame_start", {31'd0, frame_start}, 0);
        model_reset();
        @(posedge clock); #1;
        compare_all();
        reset_n = 1'b1;
        tick(1);
        chk("lit_restart_busy", {31'd0, busy}, 1);
        tick(1);
        chk("lit_restart_fs", {31'd0, frame_start}, 1);
        repeat (40) tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
